// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer for the ARM-style datapath.
// Strobes decode the current state and the instruction fields latched in DECODE; counters track retires and cycles.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic [1:0]             TypeCode,
  input  logic                   Load,
  input  logic                   set_cond_bit,
  input  logic                   should_store_link,
  input  logic                   write_condition,
  output logic                   ir_load,
  output logic                   imem_req,
  output logic                   dmem_req,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic                   link_write,
  output logic                   cpsr_write,
  output logic                   pc_write,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] retired_count,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  // Last wait-counter value still tolerated; one more unready cycle trips the timeout.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [1:0]       type_q;
  logic             load_q;
  logic             scb_q;
  logic             ssl_q;
  logic [7:0]       wait_q;
  logic             error_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic [COUNT_WIDTH-1:0] cycle_q;

  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign error         = error_q;
  assign retired_count = retired_q;
  assign cycle_count   = cycle_q;

  // Outputs are forced low while reset is held so an aborted instruction emits nothing.
  always_comb begin
    ir_load    = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    link_write = 1'b0;
    cpsr_write = 1'b0;
    pc_write   = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
        end
        S_EXECUTE: begin
          if (type_q != 2'b11) begin
            if (!write_condition) begin
              pc_write = 1'b1;
            end else begin
              case (type_q)
                2'b00:   cpsr_write = scb_q;
                2'b10: begin
                  pc_write   = 1'b1;
                  link_write = ssl_q;
                end
                default: ;
              endcase
            end
          end
        end
        S_MEMORY: begin
          dmem_req  = 1'b1;
          mem_write = load_q;
          pc_write  = dmem_ready & load_q;
        end
        S_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      type_q    <= '0;
      load_q    <= 1'b0;
      scb_q     <= 1'b0;
      ssl_q     <= 1'b0;
      wait_q    <= '0;
      error_q   <= 1'b0;
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q <= cycle_q + 1'b1;
      if (pc_write) retired_q <= retired_q + 1'b1;
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            state_q <= S_DECODE;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_HALT;
            error_q <= 1'b1;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          type_q  <= TypeCode;
          load_q  <= Load;
          scb_q   <= set_cond_bit;
          ssl_q   <= should_store_link;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (type_q == 2'b11) state_q <= S_HALT;
          else if (!write_condition) state_q <= S_FETCH;
          else begin
            case (type_q)
              2'b00:   state_q <= S_WRITEBACK;
              2'b01:   state_q <= S_MEMORY;
              default: state_q <= S_FETCH;
            endcase
          end
        end
        S_MEMORY: begin
          if (dmem_ready) begin
            state_q <= load_q ? S_FETCH : S_WRITEBACK;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_HALT;
            error_q <= 1'b1;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WRITEBACK: state_q <= S_FETCH;
        S_HALT:      state_q <= S_HALT;
        default: begin
          state_q <= S_HALT;
          error_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks each instruction class, timeouts and resets cycle by cycle.
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_ready, dmem_ready;
  logic [1:0]  TypeCode;
  logic        Load, set_cond_bit, should_store_link, write_condition;
  logic        ir_load, imem_req, dmem_req, mem_write, reg_write, link_write, cpsr_write, pc_write;
  logic [2:0]  state;
  logic        halted, error;
  logic [31:0] retired_count, cycle_count;
  logic [7:0]  strb;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  multicycle_sequencer #(.TIMEOUT_CYCLES(15), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .TypeCode(TypeCode), .Load(Load), .set_cond_bit(set_cond_bit),
    .should_store_link(should_store_link), .write_condition(write_condition),
    .ir_load(ir_load), .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write),
    .reg_write(reg_write), .link_write(link_write), .cpsr_write(cpsr_write), .pc_write(pc_write),
    .state(state), .halted(halted), .error(error),
    .retired_count(retired_count), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // Bit order: ir_load imem_req dmem_req mem_write reg_write link_write cpsr_write pc_write
  assign strb = {ir_load, imem_req, dmem_req, mem_write, reg_write, link_write, cpsr_write, pc_write};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [7:0] sb);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_strb"}, 32'(strb), 32'(sb));
  endtask

  task automatic counters(input string tag, input logic [31:0] ret, input logic [31:0] cyc);
    chk({tag, "_retired"}, retired_count, ret);
    chk({tag, "_cycles"}, cycle_count, cyc);
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; TypeCode = 2'b00;
    Load = 1'b0; set_cond_bit = 1'b0; should_store_link = 1'b0; write_condition = 1'b1;
    repeat (2) tick();
    step("rst", 3'd0, 8'h00);
    counters("rst", 0, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b1;

    // Data-proc with flag update: FETCH, DECODE, EXECUTE(cpsr), WRITEBACK
    imem_ready = 1'b1; TypeCode = 2'b00; set_cond_bit = 1'b1;
    step("dp_f", 3'd0, 8'hC0); tick();
    step("dp_d", 3'd1, 8'h00); tick();
    step("dp_e", 3'd2, 8'h02); tick();
    step("dp_w", 3'd4, 8'h09); tick();
    step("dp_next", 3'd0, 8'hC0);
    counters("dp", 1, 4);

    // Load with two wait cycles; TypeCode changes after DECODE must be ignored
    TypeCode = 2'b01; Load = 1'b0; set_cond_bit = 1'b0;
    step("ld_f", 3'd0, 8'hC0); tick();
    step("ld_d", 3'd1, 8'h00); tick();
    TypeCode = 2'b11;
    step("ld_e", 3'd2, 8'h00); tick();
    step("ld_m1", 3'd3, 8'h20); tick();
    step("ld_m2", 3'd3, 8'h20); tick();
    dmem_ready = 1'b1;
    step("ld_m3", 3'd3, 8'h20); tick();
    dmem_ready = 1'b0;
    step("ld_w", 3'd4, 8'h09); tick();
    counters("ld", 2, 11);

    // Store, zero-wait memory
    TypeCode = 2'b01; Load = 1'b1; dmem_ready = 1'b1;
    step("st_f", 3'd0, 8'hC0); tick();
    step("st_d", 3'd1, 8'h00); tick();
    step("st_e", 3'd2, 8'h00); tick();
    step("st_m", 3'd3, 8'h31); tick();
    dmem_ready = 1'b0;
    step("st_next", 3'd0, 8'hC0);
    counters("st", 3, 15);

    // Branch-with-link, condition passed
    TypeCode = 2'b10; Load = 1'b0; should_store_link = 1'b1;
    step("bl_f", 3'd0, 8'hC0); tick();
    step("bl_d", 3'd1, 8'h00); tick();
    step("bl_e", 3'd2, 8'h05); tick();
    counters("bl", 4, 18);

    // Branch-with-link, condition failed
    step("blnc_f", 3'd0, 8'hC0); tick();
    step("blnc_d", 3'd1, 8'h00); tick();
    write_condition = 1'b0;
    step("blnc_e", 3'd2, 8'h01); tick();
    write_condition = 1'b1; should_store_link = 1'b0;
    counters("blnc", 5, 21);

    // Ready arriving on the limit cycle wins over the timeout
    TypeCode = 2'b00; set_cond_bit = 1'b0; imem_ready = 1'b0;
    repeat (14) tick();
    step("tw_wait", 3'd0, 8'h40);
    imem_ready = 1'b1;
    step("tw_rdy", 3'd0, 8'hC0); tick();
    step("tw_d", 3'd1, 8'h00); tick();
    step("tw_e", 3'd2, 8'h00); tick();
    step("tw_w", 3'd4, 8'h09); tick();
    counters("tw", 6, 39);
    chk("tw_error", 32'(error), 0);

    // Fetch timeout from a fresh reset
    reset = 1'b0;
    step("rst2", 3'd0, 8'h00);
    counters("rst2", 0, 0);
    tick();
    reset = 1'b1; imem_ready = 1'b0;
    repeat (14) tick();
    step("to_last", 3'd0, 8'h40);
    tick();
    step("to_halt", 3'd5, 8'h00);
    chk("to_halted", 32'(halted), 1);
    chk("to_error", 32'(error), 1);
    counters("to", 0, 15);
    imem_ready = 1'b1;
    repeat (3) tick();
    step("to_hold", 3'd5, 8'h00);
    counters("to_hold", 0, 15);

    // Reset leaves HALT
    reset = 1'b0;
    step("rst3", 3'd0, 8'h00);
    chk("rst3_halted", 32'(halted), 0);
    chk("rst3_error", 32'(error), 0);
    tick();
    reset = 1'b1;

    // Reset asserted mid-MEMORY aborts with no strobes
    TypeCode = 2'b01; Load = 1'b0; dmem_ready = 1'b0;
    step("ab_f", 3'd0, 8'hC0); tick();
    step("ab_d", 3'd1, 8'h00); tick();
    step("ab_e", 3'd2, 8'h00); tick();
    step("ab_m", 3'd3, 8'h20);
    counters("ab_m", 0, 3);
    reset = 1'b0;
    step("ab_rst", 3'd0, 8'h00);
    counters("ab_rst", 0, 0);
    tick();
    reset = 1'b1;

    // Halt instruction: no pc_write, no retire, no error
    TypeCode = 2'b11;
    step("hi_f", 3'd0, 8'hC0); tick();
    step("hi_d", 3'd1, 8'h00); tick();
    step("hi_e", 3'd2, 8'h00); tick();
    step("hi_halt", 3'd5, 8'h00);
    chk("hi_error", 32'(error), 0);
    chk("hi_halted", 32'(halted), 1);
    counters("hi", 0, 3);

    // Data memory timeout on a store
    reset = 1'b0; tick(); reset = 1'b1;
    TypeCode = 2'b01; Load = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b1;
    step("mt_f", 3'd0, 8'hC0); tick();
    step("mt_d", 3'd1, 8'h00); tick();
    step("mt_e", 3'd2, 8'h00); tick();
    step("mt_m", 3'd3, 8'h30);
    repeat (14) tick();
    step("mt_last", 3'd3, 8'h30);
    tick();
    step("mt_halt", 3'd5, 8'h00);
    chk("mt_error", 32'(error), 1);
    counters("mt", 0, 18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
